// File: rtl/pulse_stretch_pkg.sv
// Shared timing constants and state encoding for the pulse stretcher and other timed blocks.
package pulse_stretch_pkg;

  localparam int unsigned CONTA_1S    = 32'd50_000_000;
  localparam int unsigned CONTA_100MS = 32'd5_000_000;

  typedef enum logic [1:0] {
    ST_PS_IDLE  = 2'd0,
    ST_PS_ON    = 2'd1,
    ST_PS_GUARD = 2'd2
  } estado_ps_t;

  function automatic logic [7:0] wrap_inc8(input logic [7:0] value);
    return value + 8'd1;
  endfunction

endpackage

// File: rtl/pulse_stretch_controler.sv
// State machine of the pulse stretcher: IDLE -> ON -> (GUARD) -> IDLE.
module pulse_stretch_controler
  import pulse_stretch_pkg::*;
#(
  parameter bit RETRIGGER = 1'b0,
  parameter bit GUARD_EN  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       edge_i,
  input  logic       end_on_i,
  input  logic       end_guard_i,
  output estado_ps_t state_o
);

  // State register; a retrigger edge takes priority over the ON terminal count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_o <= ST_PS_IDLE;
    end else begin
      case (state_o)
        ST_PS_IDLE: begin
          if (edge_i) state_o <= ST_PS_ON;
          else        state_o <= ST_PS_IDLE;
        end
        ST_PS_ON: begin
          if (RETRIGGER && edge_i) state_o <= ST_PS_ON;
          else if (end_on_i)       state_o <= GUARD_EN ? ST_PS_GUARD : ST_PS_IDLE;
          else                     state_o <= ST_PS_ON;
        end
        ST_PS_GUARD: begin
          if (end_guard_i) state_o <= ST_PS_IDLE;
          else             state_o <= ST_PS_GUARD;
        end
        default: state_o <= ST_PS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/registrador.sv
// Generic enabled register with synchronous active-high clear.
module registrador #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Storage element: cleared by reset, loads when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= {DATA_WIDTH{1'b0}};
    end else if (enable_i) begin
      data_o <= data_i;
    end else begin
      data_o <= data_o;
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a trigger rising edge into a TIME_ON-cycle pulse followed by a TIME_GUARD low gap.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned TIME_ON    = CONTA_1S,
  parameter int unsigned TIME_GUARD = CONTA_100MS,
  parameter bit          RETRIGGER  = 1'b0,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       trigger_i,
  output logic       signal_o,
  output logic       busy_o,
  output logic       dropped_o,
  output logic [7:0] count_o
);

  localparam logic [CNT_WIDTH-1:0] ZERO       = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ON_LAST    = CNT_WIDTH'(TIME_ON - 32'd1);
  localparam bit                   GUARD_EN   = (TIME_GUARD != 32'd0);
  localparam logic [CNT_WIDTH-1:0] GUARD_LAST = GUARD_EN ? CNT_WIDTH'(TIME_GUARD - 32'd1) : ZERO;

  logic                 trig_r;
  logic                 edge_s;
  logic                 end_on_s;
  logic                 end_guard_s;
  logic                 dropped_r;
  logic [7:0]           count_r;
  logic [CNT_WIDTH-1:0] timer_r;
  logic [CNT_WIDTH-1:0] timer_nxt_s;
  estado_ps_t           state_s;

  assign edge_s      = trigger_i & ~trig_r;
  assign end_on_s    = (state_s == ST_PS_ON) && (timer_r == ON_LAST);
  assign end_guard_s = (state_s == ST_PS_GUARD) && (timer_r == GUARD_LAST);

  pulse_stretch_controler #(
    .RETRIGGER (RETRIGGER),
    .GUARD_EN  (GUARD_EN)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .edge_i      (edge_s),
    .end_on_i    (end_on_s),
    .end_guard_i (end_guard_s),
    .state_o     (state_s)
  );

  // Timer next value: parked at zero in IDLE, cleared on every phase change or retrigger.
  always_comb begin
    timer_nxt_s = ZERO;
    case (state_s)
      ST_PS_IDLE: timer_nxt_s = ZERO;
      ST_PS_ON: begin
        if ((RETRIGGER && edge_s) || end_on_s) timer_nxt_s = ZERO;
        else                                   timer_nxt_s = timer_r + ONE;
      end
      ST_PS_GUARD: begin
        if (end_guard_s) timer_nxt_s = ZERO;
        else             timer_nxt_s = timer_r + ONE;
      end
      default: timer_nxt_s = ZERO;
    endcase
  end

  registrador #(
    .DATA_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (1'b1),
    .data_i   (timer_nxt_s),
    .data_o   (timer_r)
  );

  // Edge history, drop strobe and pulse counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_r    <= 1'b0;
      dropped_r <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      trig_r    <= trigger_i;
      dropped_r <= edge_s && (((state_s == ST_PS_ON) && !RETRIGGER) || (state_s == ST_PS_GUARD));
      if ((state_s == ST_PS_IDLE) && edge_s) count_r <= wrap_inc8(count_r);
      else                                   count_r <= count_r;
    end
  end

  assign signal_o  = (state_s == ST_PS_ON);
  assign busy_o    = (state_s != ST_PS_IDLE);
  assign dropped_o = dropped_r;
  assign count_o   = count_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// Randomised scoreboard bench for pulse_stretch across four parameter sets sharing one stimulus.
module tb_pulse_stretch;

  typedef struct packed {
    logic       signal;
    logic       busy;
    logic       dropped;
    logic [7:0] count;
  } obs_t;

  typedef obs_t [3:0] row_t;

  typedef struct {
    int         on_start;
    int         on_end;
    int         guard_end;
    logic [7:0] cnt;
    bit         prev;
  } mdl_t;

  localparam int P_ON [4] = '{4, 4, 4, 1};
  localparam int P_G  [4] = '{3, 3, 0, 2};
  localparam bit P_R  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       sig  [4];
  logic       busy [4];
  logic       drop [4];
  logic [7:0] cnt  [4];

  row_t exp_q[$];
  mdl_t m[4];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  pulse_stretch #(.TIME_ON(4), .TIME_GUARD(3), .RETRIGGER(1'b0), .CNT_WIDTH(32)) dut0 (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig),
    .signal_o(sig[0]), .busy_o(busy[0]), .dropped_o(drop[0]), .count_o(cnt[0]));
  pulse_stretch #(.TIME_ON(4), .TIME_GUARD(3), .RETRIGGER(1'b1), .CNT_WIDTH(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig),
    .signal_o(sig[1]), .busy_o(busy[1]), .dropped_o(drop[1]), .count_o(cnt[1]));
  pulse_stretch #(.TIME_ON(4), .TIME_GUARD(0), .RETRIGGER(1'b0), .CNT_WIDTH(32)) dut2 (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig),
    .signal_o(sig[2]), .busy_o(busy[2]), .dropped_o(drop[2]), .count_o(cnt[2]));
  pulse_stretch #(.TIME_ON(1), .TIME_GUARD(2), .RETRIGGER(1'b1), .CNT_WIDTH(8)) dut3 (
    .clk_i(clk), .rst_i(rst), .trigger_i(trig),
    .signal_o(sig[3]), .busy_o(busy[3]), .dropped_o(drop[3]), .count_o(cnt[3]));

  // Timestamp reference: a pulse is the window [on_start, on_end), guard is [on_end, guard_end).
  function automatic obs_t step(inout mdl_t md, input bit r, input bit t, input int n,
                                input int t_on, input int t_g, input bit rtg);
    obs_t o;
    bit   e;
    bit   dr;
    dr = 1'b0;
    if (r) begin
      md.on_start = n; md.on_end = n; md.guard_end = n; md.cnt = 8'd0; md.prev = 1'b0;
    end else begin
      e = t && !md.prev;
      md.prev = t;
      if (e) begin
        if (n > md.on_start && n <= md.on_end) begin
          if (rtg) begin
            md.on_end    = n + t_on;
            md.guard_end = md.on_end + t_g;
          end else begin
            dr = 1'b1;
          end
        end else if (n > md.on_end && n <= md.guard_end) begin
          dr = 1'b1;
        end else begin
          md.on_start  = n;
          md.on_end    = n + t_on;
          md.guard_end = md.on_end + t_g;
          md.cnt       = md.cnt + 8'd1;
        end
      end
    end
    o.signal  = (n >= md.on_start) && (n < md.on_end);
    o.busy    = (n >= md.on_start) && (n < md.guard_end);
    o.dropped = dr;
    o.count   = md.cnt;
    return o;
  endfunction

  // Reference model: predicts the outputs following each clock edge and queues them.
  initial begin
    row_t row;
    for (int i = 0; i < 4; i++) begin
      m[i].on_start = -1; m[i].on_end = -1; m[i].guard_end = -1; m[i].cnt = 8'd0; m[i].prev = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) row[i] = step(m[i], rst, trig, cyc, P_ON[i], P_G[i], P_R[i]);
      exp_q.push_back(row);
      cyc++;
    end
  end

  // Monitor: compares every DUT instance against the oldest queued prediction.
  initial begin
    row_t want;
    obs_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          got = {sig[k], busy[k], drop[k], cnt[k]};
          n_checks++;
          if (got !== want[k]) begin
            n_fail++;
            $display("FAIL outputs dut%0d cycle %0d: got sig=%b busy=%b drop=%b cnt=%0d, expected sig=%b busy=%b drop=%b cnt=%0d",
                     k, cyc - 1, got.signal, got.busy, got.dropped, got.count,
                     want[k].signal, want[k].busy, want[k].dropped, want[k].count);
          end
        end
      end
    end
  end

  task automatic tick(input bit r, input bit t);
    @(posedge clk);
    #1;
    rst  = r;
    trig = t;
  endtask

  // Stimulus: directed warm-up, random strobes/levels with occasional resets, then a long wrap run.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(1'b0, 1'b1);
    repeat (12) tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b1);
    repeat (12) tick(1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      bit t;
      bit r;
      if ((i / 500) % 2 == 0) t = ($urandom_range(0, 4) == 0);
      else                    t = ($urandom_range(0, 7) == 0) ? !trig : trig;
      r = ($urandom_range(0, 149) == 0);
      tick(r, t);
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 2400; i++) tick(1'b0, (i % 9) == 0);
    repeat (3) tick(1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
